// File: rtl/clk_div_monitor.sv
`default_nettype none
// ============================================================================
// Module : clk_div_monitor
// Desc   : Measures period/high time of a divided clock sampled in clk_in,
//          reports lock, mismatch (sticky err) and stall. Optional macro
//          CLK_DIV_MON_SYNC_EN adds a 2-flop synchronizer on mon_clk.
// Rev    : 1.0
// ============================================================================
module clk_div_monitor #(
    parameter int EXP_DIV  = 4,
    parameter int TOL      = 0,
    parameter int LOCK_CNT = 4,
    parameter int CNT_W    = 16
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             mon_clk,
    input  logic             clear,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             period_vld,
    output logic             locked,
    output logic             err,
    output logic             stall
);

    localparam int                 MATCH_W   = $clog2(LOCK_CNT + 1);
    localparam logic [MATCH_W-1:0] MATCH_TGT = MATCH_W'(LOCK_CNT);
    localparam logic [CNT_W-1:0]   TIMEOUT   = CNT_W'(2 * EXP_DIV);
    localparam logic [CNT_W-1:0]   CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W:0]     LO_LIM    = (TOL >= EXP_DIV) ? {(CNT_W+1){1'b0}}
                                                                : (CNT_W+1)'(EXP_DIV - TOL);
    localparam logic [CNT_W:0]     HI_LIM    = (CNT_W+1)'(EXP_DIV + TOL);

    typedef enum logic [1:0] {
        SEEK = 2'd0,
        ACQ  = 2'd1,
        LOCK = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic               s, s_d;
    logic [CNT_W-1:0]   cnt, hcnt;
    logic [MATCH_W-1:0] match, match_nxt, match_inc;
    logic               rise, in_tol, emit, lock_set, lock_clr, err_set, stall_set;

`ifdef CLK_DIV_MON_SYNC_EN
    logic sync_a, sync_b;

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            sync_a <= 1'b0;
            sync_b <= 1'b0;
            s      <= 1'b0;
        end else begin
            sync_a <= mon_clk;
            sync_b <= sync_a;
            s      <= sync_b;
        end
    end
`else
    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            s <= 1'b0;
        end else begin
            s <= mon_clk;
        end
    end
`endif

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            s_d <= 1'b0;
        end else begin
            s_d <= s;
        end
    end

    assign rise      = s & ~s_d;
    assign in_tol    = ({1'b0, cnt} >= LO_LIM) && ({1'b0, cnt} <= HI_LIM);
    assign match_inc = match + MATCH_W'(1);

    // The rise sample itself is the first cycle (and first high sample) of the
    // new period, so at the next rise cnt equals the period directly.
    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            cnt  <= '0;
            hcnt <= '0;
        end else if (rise) begin
            cnt  <= CNT_W'(1);
            hcnt <= CNT_W'(1);
        end else begin
            if (cnt != CNT_MAX) begin
                cnt <= cnt + CNT_W'(1);
            end
            if (s && (hcnt != CNT_MAX)) begin
                hcnt <= hcnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        match_nxt = match;
        emit      = 1'b0;
        lock_set  = 1'b0;
        lock_clr  = 1'b0;
        err_set   = 1'b0;
        stall_set = 1'b0;
        case (state)
            SEEK: begin
                if (rise) begin
                    state_nxt = ACQ;
                    match_nxt = '0;
                end
            end
            ACQ: begin
                if (rise) begin
                    emit = 1'b1;
                    if (in_tol) begin
                        match_nxt = match_inc;
                        if (match_inc == MATCH_TGT) begin
                            state_nxt = LOCK;
                            lock_set  = 1'b1;
                        end
                    end else begin
                        match_nxt = '0;
                    end
                end else if (cnt == TIMEOUT) begin
                    stall_set = 1'b1;
                    lock_clr  = 1'b1;
                    match_nxt = '0;
                    state_nxt = SEEK;
                end
            end
            LOCK: begin
                if (rise) begin
                    emit = 1'b1;
                    if (!in_tol) begin
                        err_set   = 1'b1;
                        lock_clr  = 1'b1;
                        match_nxt = '0;
                        state_nxt = ACQ;
                    end
                end else if (cnt == TIMEOUT) begin
                    stall_set = 1'b1;
                    err_set   = 1'b1;
                    lock_clr  = 1'b1;
                    match_nxt = '0;
                    state_nxt = SEEK;
                end
            end
            default: begin
                state_nxt = SEEK;
                match_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            state      <= SEEK;
            match      <= '0;
            period     <= '0;
            high_time  <= '0;
            period_vld <= 1'b0;
            locked     <= 1'b0;
            err        <= 1'b0;
            stall      <= 1'b0;
        end else begin
            state      <= state_nxt;
            match      <= match_nxt;
            period_vld <= emit;
            if (emit) begin
                period    <= cnt;
                high_time <= hcnt;
            end
            if (lock_set) begin
                locked <= 1'b1;
            end else if (lock_clr) begin
                locked <= 1'b0;
            end
            // An error event beats a simultaneous clear.
            if (err_set) begin
                err <= 1'b1;
            end else if (clear) begin
                err <= 1'b0;
            end
            if (stall_set) begin
                stall <= 1'b1;
            end else if (rise) begin
                stall <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_clk_div_monitor.sv
`default_nettype none
// ============================================================================
// Module : tb_clk_div_monitor
// Desc   : Random + directed stimulus on two monitors (TOL=0, TOL=1) checked
//          every cycle against a sample-history reference model.
// Rev    : 1.0
// ============================================================================
module tb_clk_div_monitor;

    localparam int EXP_DIV  = 4;
    localparam int LOCK_CNT = 4;
    localparam int CNT_W    = 16;
    localparam int NCYC     = 4000;
`ifdef CLK_DIV_MON_SYNC_EN
    localparam int DLY = 3;
`else
    localparam int DLY = 1;
`endif
    localparam int M_SEEK = 0;
    localparam int M_ACQ  = 1;
    localparam int M_LOCK = 2;

    logic clk_in  = 1'b0;
    logic rst_n   = 1'b0;
    logic mon_clk = 1'b0;
    logic clear   = 1'b0;

    logic [CNT_W-1:0] period0, high0, period1, high1;
    logic             vld0, lock0, err0, stall0;
    logic             vld1, lock1, err1, stall1;

    always #5 clk_in = ~clk_in;

    clk_div_monitor #(.EXP_DIV(EXP_DIV), .TOL(0), .LOCK_CNT(LOCK_CNT), .CNT_W(CNT_W)) u_dut0 (
        .clk_in(clk_in), .rst_n(rst_n), .mon_clk(mon_clk), .clear(clear),
        .period(period0), .high_time(high0), .period_vld(vld0),
        .locked(lock0), .err(err0), .stall(stall0)
    );

    clk_div_monitor #(.EXP_DIV(EXP_DIV), .TOL(1), .LOCK_CNT(LOCK_CNT), .CNT_W(CNT_W)) u_dut1 (
        .clk_in(clk_in), .rst_n(rst_n), .mon_clk(mon_clk), .clear(clear),
        .period(period1), .high_time(high1), .period_vld(vld1),
        .locked(lock1), .err(err1), .stall(stall1)
    );

    // Driven stimulus history, indexed by clock edge number.
    bit dv [NCYC];
    bit rv [NCYC];
    bit cl [NCYC];
    int last_rst = -1000;

    // Entry bits: {reset, clear, level}
    logic [2:0] stim_q [$];

    int total = 0;
    int bad   = 0;

    int m_mode [2], m_lr [2], m_match [2], e_per [2], e_high [2];
    bit e_vld [2], e_lock [2], e_err [2], e_stall [2];

    task automatic chk(string tag, int cyc, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s @cycle %0d: got=%0d expected=%0d", tag, cyc, got, exp);
        end
    endtask

    task automatic push_period(int p, int h, bit rnd);
        for (int i = 0; i < p; i++) begin
            stim_q.push_back({1'b0, rnd && ($urandom_range(0, 7) == 0), (i < h)});
        end
    endtask

    task automatic push_reset();
        stim_q.push_back(3'b100);
    endtask

    task automatic gen_random();
        int r, p, h;
        if ($urandom_range(0, 59) == 0) push_reset();
        r = $urandom_range(0, 99);
        if (r < 50) begin
            p = EXP_DIV;
            h = $urandom_range(1, p - 1);
        end else if (r < 72) begin
            p = $urandom_range(EXP_DIV - 1, EXP_DIV + 1);
            h = $urandom_range(1, p - 1);
        end else if (r < 86) begin
            p = $urandom_range(2, 2 * EXP_DIV + 1);
            h = $urandom_range(1, p - 1);
        end else if (r < 93) begin
            h = $urandom_range(1, 2);
            p = h + $urandom_range(2 * EXP_DIV, 2 * EXP_DIV + 6);
        end else begin
            h = $urandom_range(2 * EXP_DIV - 2, 2 * EXP_DIV + 4);
            p = h + $urandom_range(1, 3);
        end
        push_period(p, h, 1'b1);
    endtask

    // Sample value the detector sees for stimulus index i; anything captured
    // at or before the most recent reset is flushed to 0.
    function automatic int val(int i);
        return (i >= 0 && i > last_rst) ? int'(dv[i]) : 0;
    endfunction

    task automatic model_reset(int k);
        m_mode[k]  = M_SEEK;
        m_lr[k]    = 0;
        m_match[k] = 0;
        e_per[k]   = 0;
        e_high[k]  = 0;
        e_vld[k]   = 1'b0;
        e_lock[k]  = 1'b0;
        e_err[k]   = 1'b0;
        e_stall[k] = 1'b0;
    endtask

    task automatic model_step(int k, int tol, int m);
        int j, p, h, dev;
        bit rise, err_evt;
        if (!rv[m]) begin
            model_reset(k);
            return;
        end
        j       = m - DLY;
        rise    = (val(j) == 1) && (val(j - 1) == 0);
        err_evt = 1'b0;
        e_vld[k] = 1'b0;
        if (rise) begin
            if (m_mode[k] != M_SEEK) begin
                p = j - m_lr[k];
                h = 0;
                for (int i = m_lr[k]; i < j; i++) h += val(i);
                e_per[k]  = p;
                e_high[k] = h;
                e_vld[k]  = 1'b1;
                dev = (p > EXP_DIV) ? p - EXP_DIV : EXP_DIV - p;
                if (m_mode[k] == M_ACQ) begin
                    if (dev <= tol) begin
                        m_match[k]++;
                        if (m_match[k] == LOCK_CNT) begin
                            m_mode[k] = M_LOCK;
                            e_lock[k] = 1'b1;
                        end
                    end else begin
                        m_match[k] = 0;
                    end
                end else if (dev > tol) begin
                    err_evt    = 1'b1;
                    e_lock[k]  = 1'b0;
                    m_match[k] = 0;
                    m_mode[k]  = M_ACQ;
                end
            end else begin
                m_mode[k]  = M_ACQ;
                m_match[k] = 0;
            end
            m_lr[k]    = j;
            e_stall[k] = 1'b0;
        end else if (m_mode[k] != M_SEEK && (j - m_lr[k]) == 2 * EXP_DIV) begin
            e_stall[k] = 1'b1;
            e_lock[k]  = 1'b0;
            if (m_mode[k] == M_LOCK) err_evt = 1'b1;
            m_mode[k]  = M_SEEK;
            m_match[k] = 0;
        end
        if (err_evt) e_err[k] = 1'b1;
        else if (cl[m]) e_err[k] = 1'b0;
    endtask

    initial begin
        logic [2:0] ent;
        model_reset(0);
        model_reset(1);

        // Divide-by-4 lock, switch to /6, stall, resume, 4/5 mix, reset while locked.
        repeat (3) push_reset();
        repeat (7) push_period(4, 2, 1'b0);
        repeat (2) push_period(6, 3, 1'b0);
        push_period(12, 0, 1'b0);
        repeat (6) push_period(4, 2, 1'b0);
        repeat (4) begin
            push_period(4, 2, 1'b0);
            push_period(5, 2, 1'b0);
        end
        push_reset();
        repeat (7) push_period(4, 2, 1'b0);

        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(negedge clk_in);
            if (stim_q.size() == 0) gen_random();
            ent     = stim_q.pop_front();
            rst_n   = ~ent[2];
            clear   = ent[1];
            mon_clk = ent[0];
            dv[cyc] = ent[0];
            rv[cyc] = ~ent[2];
            cl[cyc] = ent[1];
            if (ent[2]) last_rst = cyc;
            @(posedge clk_in);
            #1;
            model_step(0, 0, cyc);
            model_step(1, 1, cyc);
            chk("t0_period_vld", cyc, 32'(vld0),    32'(e_vld[0]));
            chk("t0_period",     cyc, 32'(period0), 32'(e_per[0]));
            chk("t0_high_time",  cyc, 32'(high0),   32'(e_high[0]));
            chk("t0_locked",     cyc, 32'(lock0),   32'(e_lock[0]));
            chk("t0_err",        cyc, 32'(err0),    32'(e_err[0]));
            chk("t0_stall",      cyc, 32'(stall0),  32'(e_stall[0]));
            chk("t1_period_vld", cyc, 32'(vld1),    32'(e_vld[1]));
            chk("t1_period",     cyc, 32'(period1), 32'(e_per[1]));
            chk("t1_high_time",  cyc, 32'(high1),   32'(e_high[1]));
            chk("t1_locked",     cyc, 32'(lock1),   32'(e_lock[1]));
            chk("t1_err",        cyc, 32'(err1),    32'(e_err[1]));
            chk("t1_stall",      cyc, 32'(stall1),  32'(e_stall[1]));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/clk_div_monitor.md
# clk_div_monitor

Checks a divided clock from the clock divider against its source clock. The divided clock is sampled as data in the `clk_in` domain. The block measures the period and high time of each divided-clock cycle in source-clock cycles and compares the period with the expected division factor. It reports lock, mismatch and stall status. It sits beside the clock divider as its checker, both as a bring-up aid and as a run-time health monitor.

## Interface
- `EXP_DIV`, default 4, expected divide ratio in `clk_in` cycles; must be ≥ 2.
- `TOL`, default 0, allowed absolute period deviation in cycles.
- `LOCK_CNT`, default 4, number of consecutive in-tolerance periods required to assert lock; must be ≥ 1.
- `CNT_W`, default 16, counter and output width; must hold 2·`EXP_DIV`.
- `clk_in`  in  1  source clock; the only clock.
- `rst_n`  in  1  synchronous, active-low reset, sampled on the rising edge of `clk_in`.
- `mon_clk`  in  1  divided clock under test, sampled as data.
- `clear`  in  1  clears the sticky `err` flag.
- `period`  out  `CNT_W`  last measured period, in `clk_in` cycles.
- `high_time`  out  `CNT_W`  cycles sampled high within the last measured period.
- `period_vld`  out  1  one-cycle pulse when `period` and `high_time` update.
- `locked`  out  1  divided clock matches `EXP_DIV` within `TOL`.
- `err`  out  1  sticky flag: a mismatch or stall occurred while locked.
- `stall`  out  1  no rising edge seen for 2·`EXP_DIV` cycles.

## Operation
- Edge detect: `s` is the sampled `mon_clk` and `s_d` is `s` delayed by one cycle. A rise is `s & ~s_d`.
- `cnt` counts the cycles since the last rise and saturates at all ones. `hcnt` counts the cycles with `s` = 1 since the last rise.
- For edges detected at samples n and n+P: `period` = P, and `high_time` = the number of high samples in that interval.
- States:
  - SEEK: waits for a rise. The first rise loads `cnt`/`hcnt` without emitting a measurement, then moves to ACQ.
  - ACQ: on each rise, emit a measurement.
    - In tolerance (|P − `EXP_DIV`| ≤ `TOL`): `match` += 1.
    - Out of tolerance: `match` = 0.
    - When `match` reaches `LOCK_CNT`: move to LOCK and set `locked` = 1.
  - LOCK: on each rise, emit a measurement.
    - Out of tolerance: `err` = 1, `locked` = 0, `match` = 0, move to ACQ.
- Timeout, in any state except SEEK: when `cnt` reaches 2·`EXP_DIV` with no rise:
  - `stall` = 1, `locked` = 0, move to SEEK.
  - If the block was in LOCK, also set `err` = 1.
- `stall` clears on the next detected rise. That rise is treated as the SEEK first rise, so no `period_vld`.
- `clear` sets `err` = 0. If an error event occurs in the same cycle, the set wins and `err` = 1.
- Duty cycle is reported through `high_time` only. It is never checked.

## Timing
- Reset values: `period` = 0, `high_time` = 0, `period_vld` = 0, `locked` = 0, `err` = 0, `stall` = 0, state = SEEK, all counters = 0.
- Base sample path: `mon_clk` is registered once, so `s` lags `mon_clk` by 1 cycle.
- `period_vld`, `period` and `high_time` are registered outputs. They update 1 cycle after the detected rise.
- `locked`, `err` and `stall` update in the same registered cycle as the `period_vld` or timeout that causes them.
- `period_vld` is high for exactly 1 cycle per measurement. Consecutive pulses are spaced at least 2 cycles apart.
- Reset mid-operation: every output returns to its reset value at the first rising edge of `clk_in` with `rst_n` = 0. Nothing is retained.
- Counter saturation: `cnt` never wraps. Timeout therefore fires at most once per stall.

## Configuration
- `CLK_DIV_MON_SYNC_EN`:
  - Defined: `mon_clk` passes through an extra 2-flop synchronizer before the edge detector, for use with an asynchronous source. Edge-to-`period_vld` latency grows by 2 cycles. The measured values are unchanged.
  - Undefined: single sample register only, for a divided clock generated from `clk_in`.

## Test plan
- Divide-by-4 `mon_clk` (2 high, 2 low) after reset. Required response:
  - First `period_vld` on the 2nd rise, with `period` = 4 and `high_time` = 2.
  - `locked` = 1 together with the 4th `period_vld`.
  - `err` = 0 throughout.
- While locked, switch to divide-by-6. Required response: the next `period_vld` shows `period` = 6 and `high_time` = 3, with `err` = 1 and `locked` = 0 in the same cycle.
- Hold `mon_clk` low.
  - `stall` = 1 when `cnt` reaches 8, with `locked` = 0 and `err` = 1.
  - Resume toggling: `stall` = 0 on the first rise, with no `period_vld` on that rise.
- `TOL` = 1, periods alternating 4, 5, 4, 5. Required response: `locked` = 1 after 4 measurements; `err` stays 0.
- `clear` asserted in the same cycle as a LOCK mismatch leaves `err` = 1. `clear` alone on a later cycle gives `err` = 0.
- While locked, `rst_n` = 0 for 1 cycle. Required response:
  - All outputs are 0 on the next edge.
  - Re-lock follows the first scenario's timing.
  - With `CLK_DIV_MON_SYNC_EN` defined, every latency is 2 cycles longer.
